// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
// The optional performance counters are enabled with PIPE_CTRL_PERF_EN.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } state_t;

  // x0 is hardwired to zero, so a load that targets it never creates a hazard.
  localparam int REG_ZERO = 0;

  // The MDU wait counter is never narrower than one bit.
  localparam int CNT_W_MIN = 1;

  function automatic int cnt_width(input int lat);
    int w;
    w = $clog2(lat);
    return (w < CNT_W_MIN) ? CNT_W_MIN : w;
  endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard compare between the instruction in ID and a load in EX.
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  output logic              load_use
);

  localparam logic [REG_AW-1:0] RD_ZERO = REG_AW'(REG_ZERO);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit  = id_use_rs2 && (id_rs2 == ex_rd);
  assign load_use = ex_mem_read && (ex_rd != RD_ZERO) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush/freeze sequencing for the 5-stage core (load-use, branch, MDU).
// Define PIPE_CTRL_PERF_EN to build the stall and redirect counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MDU_LAT = 4,
  parameter int REG_AW  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_is_mdu,
  input  logic              ex_branch_taken,
  output logic              pc_we,
  output logic              if_id_en,
  output logic              if_id_flush,
  output logic              id_ex_en,
  output logic              id_ex_flush,
  output logic              ex_mem_flush,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
);

  localparam int             CNT_W     = cnt_width(MDU_LAT);
  localparam bit             MDU_MULTI = (MDU_LAT > 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = MDU_MULTI ? CNT_W'(MDU_LAT - 2) : '0;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             load_use;

  hazard_detect #(
    .REG_AW (REG_AW)
  ) u_hazard_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .load_use    (load_use)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Outputs are combinational so an asynchronous reset takes effect mid-cycle.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    pc_we        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;

    case (state)
      RUN: begin
        if (ex_branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (ex_is_mdu && MDU_MULTI) begin
          pc_we        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_en     = 1'b0;
          ex_mem_flush = 1'b1;
          cnt_nxt      = CNT_LOAD;
          state_nxt    = MDU_WAIT;
        end else if (load_use) begin
          pc_we       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
        end
      end
      MDU_WAIT: begin
        // The final wait cycle lets the result advance; ex_is_mdu is still
        // high here for the same op, so it must not re-enter the wait.
        if (cnt != '0) begin
          pc_we        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_en     = 1'b0;
          ex_mem_flush = 1'b1;
          cnt_nxt      = cnt - CNT_W'(1);
        end else begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
    endcase

    if (rst) begin
      pc_we        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic branch_act;

  assign branch_act = (state == RUN) && ex_branch_taken && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_we)     stall_cnt <= stall_cnt + 32'd1;
      if (branch_act) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (MDU_LAT=4 main, MDU_LAT=1 side).
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int REG_AW = 5;

  // {pc_we, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_flush}
  localparam logic [5:0] V_RST    = 6'b001011;
  localparam logic [5:0] V_DEF    = 6'b110100;
  localparam logic [5:0] V_LU     = 6'b000110;
  localparam logic [5:0] V_BR     = 6'b111110;
  localparam logic [5:0] V_FREEZE = 6'b000001;

  logic              clk;
  logic              rst;
  logic [REG_AW-1:0] id_rs1, id_rs2, ex_rd;
  logic              id_use_rs1, id_use_rs2, ex_mem_read, ex_is_mdu, ex_branch_taken;

  logic        pc_we, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_flush;
  logic [31:0] stall_cnt, flush_cnt;
  logic        pc_we_1, if_id_en_1, if_id_flush_1, id_ex_en_1, id_ex_flush_1, ex_mem_flush_1;
  logic [31:0] stall_cnt_1, flush_cnt_1;

  logic [5:0] ctl, ctl_1;
  assign ctl   = {pc_we, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_flush};
  assign ctl_1 = {pc_we_1, if_id_en_1, if_id_flush_1, id_ex_en_1, id_ex_flush_1, ex_mem_flush_1};

  int n_chk  = 0;
  int n_pass = 0;

  pipe_ctrl #(.MDU_LAT(4), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_is_mdu(ex_is_mdu),
    .ex_branch_taken(ex_branch_taken),
    .pc_we(pc_we), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_ctrl #(.MDU_LAT(1), .REG_AW(REG_AW)) dut_lat1 (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_is_mdu(ex_is_mdu),
    .ex_branch_taken(ex_branch_taken),
    .pc_we(pc_we_1), .if_id_en(if_id_en_1), .if_id_flush(if_id_flush_1),
    .id_ex_en(id_ex_en_1), .id_ex_flush(id_ex_flush_1), .ex_mem_flush(ex_mem_flush_1),
    .stall_cnt(stall_cnt_1), .flush_cnt(flush_cnt_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Branches and load-use must never be presented while EX holds an MDU op.
  always @(negedge clk) begin
    if (!rst && dut.state == MDU_WAIT)
      assert (!ex_branch_taken && !dut.load_use)
        else $error("illegal branch/load-use during MDU_WAIT");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic set_in(input logic [REG_AW-1:0] rs1, input logic [REG_AW-1:0] rs2,
                        input logic u1, input logic u2, input logic [REG_AW-1:0] rd,
                        input logic mr, input logic mdu, input logic br);
    id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    ex_rd = rd; ex_mem_read = mr; ex_is_mdu = mdu; ex_branch_taken = br;
  endtask

  task automatic idle();
    set_in('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  // Check the main DUT at the negative edge, then advance to just past the next rising edge.
  task automatic tick_check(input string tag, input logic [5:0] exp);
    @(negedge clk);
    check(tag, 32'(ctl), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();

    // Reset held three cycles.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_ctl", 32'(ctl), 32'(V_RST));
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick_check("release_default", V_DEF);

    // Load-use on rs2: single stall, then the load has moved on.
    set_in(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    tick_check("load_use_rs2", V_LU);
    idle();
    tick_check("after_load_use", V_DEF);

    set_in(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
    tick_check("load_rd_zero", V_DEF);
    set_in(5'd0, 5'd5, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    tick_check("load_rs2_unused", V_DEF);

    // Branch wins over a simultaneous load-use.
    set_in(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1);
    tick_check("branch_over_lu", V_BR);
    idle();

    // MDU held for four cycles: three frozen, fourth lets it go; LAT=1 never stalls.
    set_in('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("lat1_mdu", 32'(ctl_1), 32'(V_DEF));
      check("mdu_seq", 32'(ctl), 32'((i < 3) ? V_FREEZE : V_DEF));
      @(posedge clk);
      #1;
    end
    idle();
    tick_check("mdu_done", V_DEF);

`ifdef PIPE_CTRL_PERF_EN
    check("stall_cnt", stall_cnt, 32'd4);
    check("flush_cnt", flush_cnt, 32'd1);
`else
    check("stall_cnt_off", stall_cnt, 32'd0);
    check("flush_cnt_off", flush_cnt, 32'd0);
`endif

    // Extra vectors: rs1 path, and branch over an MDU op.
    set_in(5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
    tick_check("load_use_rs1", V_LU);
    set_in('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
    tick_check("branch_over_mdu", V_BR);
    idle();
    tick_check("after_branch_mdu", V_DEF);

    // Reset during the second MDU_WAIT cycle.
    set_in('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    tick_check("mw_entry", V_FREEZE);
    tick_check("mw_wait1", V_FREEZE);
    @(negedge clk);
    check("mw_wait2", 32'(ctl), 32'(V_FREEZE));
    rst = 1'b1;
    #1;
    check("mw_async_rst", 32'(ctl), 32'(V_RST));
    @(posedge clk);
    #1;
    rst = 1'b0;
    // Back in RUN with a fresh counter: a new MDU op gets the full freeze.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mw_restart", 32'(ctl), 32'((i < 3) ? V_FREEZE : V_DEF));
      @(posedge clk);
      #1;
    end
    idle();
    tick_check("mw_final", V_DEF);

`ifdef PIPE_CTRL_PERF_EN
    check("stall_cnt_post_rst", stall_cnt, 32'd3);
    check("flush_cnt_post_rst", flush_cnt, 32'd0);
`else
    check("stall_cnt_off2", stall_cnt, 32'd0);
    check("flush_cnt_off2", flush_cnt, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
